midi_tx: RTL

- MIDI OUT transmitter: accepts one complete MIDI message per valid/ready handshake and serializes it onto a 31250-baud 8N1 UART line.
- Sits between the synth control logic (MIDI thru, sequencer, panel controls) and the MIDI OUT pin.
- Mirror of the receive path: the decoder produces status + two data bytes; this block consumes the same three-byte format.

---
 rtl/midi_pkg.sv | 51 +++++
 rtl/midi_uart_tx_byte.sv | 77 +++++++
 rtl/midi_tx.sv | 106 ++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI constants, FSM state types and the message-length decoder
// used by the MIDI OUT transmitter.
package midi_pkg;

  localparam int MIDI_BAUD = 31250;

  // Status-byte upper nibbles
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CH_AT    = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;
  localparam logic [3:0] SYS      = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND
  } msg_state_e;

  typedef enum logic [1:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP
  } bit_state_e;

  // Total bytes in the message introduced by this status byte; 0 = not a status byte.
  function automatic logic [1:0] midi_msg_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    if (status[7]) begin
      case (status[7:4])
        NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: len = 2'd3;
        PROG, CH_AT:                           len = 2'd2;
        SYS: begin
          case (status[3:0])
            4'h1, 4'h3: len = 2'd2;
            4'h2:       len = 2'd3;
            default:    len = 2'd1;
          endcase
        end
        default: len = 2'd0;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/midi_uart_tx_byte.sv
// midi_uart_tx_byte: single-byte 8N1 serializer. tx is registered from the bit
// phase, so the line trails the phase by one clock; done marks the last STOP cycle.
module midi_uart_tx_byte
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       done,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  bit_state_e    state, state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          bit_end;

  assign bit_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));

  // NOTE: every always_comb output gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      BIT_IDLE:  if (start) state_nxt = BIT_START;
      BIT_START: if (bit_end) state_nxt = BIT_DATA;
      BIT_DATA:  if (bit_end && bit_cnt == 3'd7) state_nxt = BIT_STOP;
      BIT_STOP: begin
        if (bit_end) begin
          done      = 1'b1;
          state_nxt = BIT_IDLE;
        end
      end
      default: state_nxt = BIT_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= BIT_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      tx       <= 1'b1;
    end else begin
      state <= state_nxt;
      case (state)
        BIT_START: tx <= 1'b0;
        BIT_DATA:  tx <= shift_q[0];
        default:   tx <= 1'b1;
      endcase
      if (state == BIT_IDLE) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
        if (start) shift_q <= data;
      end else if (bit_end) begin
        baud_cnt <= '0;
        if (state == BIT_DATA) begin
          bit_cnt <= bit_cnt + 3'd1;
          shift_q <= {1'b0, shift_q[7:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/midi_tx.sv
// midi_tx: MIDI OUT message sequencer feeding an 8N1 byte serializer.
// Optional running-status suppression is enabled by defining MIDI_TX_RUNNING_STATUS_EN.
module midi_tx
  import midi_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = MIDI_BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic [7:0] msg_byte0,
  input  logic [7:0] msg_byte1,
  input  logic [7:0] msg_byte2,
  output logic       tx,
  output logic       busy,
  output logic       msg_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

  msg_state_e      state, state_nxt;
  logic [2:0][7:0] msg_q;
  logic [1:0]      idx_q, last_q;
  logic [1:0]      msg_len;
  logic            ready_q, err_q;
  logic            transfer, byte_start, byte_done, rs_hit;

  assign msg_len  = midi_msg_len(msg_byte0);
  assign transfer = msg_valid & ready_q;

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] rs_q;  // 8'h00 means no running status held
  logic       is_chan;

  assign is_chan = (msg_byte0 >= 8'h80) && (msg_byte0 <= 8'hEF);
  assign rs_hit  = is_chan && (msg_byte0 == rs_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_q <= 8'h00;
    end else if (transfer && msg_len != 2'd0) begin
      if (is_chan) rs_q <= msg_byte0;
      else if (msg_byte0[7:3] == 5'b11110) rs_q <= 8'h00;
    end
  end
`else
  assign rs_hit = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    byte_start = 1'b0;
    case (state)
      ST_IDLE: if (transfer && msg_len != 2'd0) state_nxt = ST_LOAD;
      ST_LOAD: begin
        byte_start = 1'b1;
        state_nxt  = ST_SEND;
      end
      ST_SEND: if (byte_done) state_nxt = (idx_q == last_q) ? ST_IDLE : ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // msg_ready reopens one cycle after the FSM reaches IDLE, which is when the
  // registered line finishes the final stop bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      // NOTE: the byte buffer is small and reset so nothing undefined ever reaches tx.
      msg_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state == ST_IDLE) && (state_nxt == ST_IDLE);
      err_q   <= transfer && (msg_len == 2'd0);
      if (transfer && msg_len != 2'd0) begin
        msg_q  <= {{1'b0, msg_byte2[6:0]}, {1'b0, msg_byte1[6:0]}, msg_byte0};
        idx_q  <= rs_hit ? 2'd1 : 2'd0;
        last_q <= msg_len - 2'd1;
      end else if (state == ST_SEND && byte_done && idx_q != last_q) begin
        idx_q <= idx_q + 2'd1;
      end
    end
  end

  midi_uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk  (clk),
    .reset(reset),
    .start(byte_start),
    .data (msg_q[idx_q]),
    .done (byte_done),
    .tx   (tx)
  );

  assign msg_ready = ready_q;
  assign busy      = ~ready_q;
  assign msg_err   = err_q;

endmodule
